alu_pipe_acc: RTL and testbench
===============================

# alu_pipe_acc

Two-stage pipelined signed ALU with a valid/ready handshake on both sides, an internal accumulator that can replace the X operand, and status flags. It generalises the team's combinational 8-op ALU to a streaming datapath with a parametrised operand width. Throughput is one operation per cycle, and latency is two cycles when the output is not stalled. It sits between an operand producer and a result consumer, and both may apply backpressure.

## Interface
- N, default 4, operand width in bits (N ≥ 2); results are N+2 bits.
- clk input 1 — the single clock; rising edge.
- rst_n input 1 — asynchronous, active-low reset.
- in_valid input 1 — the producer presents an operation.
- in_ready output 1 — the block can accept an operation this cycle.
- X input N — signed operand A, used when USE_ACC=0.
- Y input N — signed operand B.
- SEL input 3 — opcode.
- USE_ACC input 1 — operand A is the saturated accumulator instead of X.
- ACC_CLR input 1 — synchronous clear of the accumulator; independent of the handshake.
- out_valid output 1 — OUT and the flags hold a result.
- out_ready input 1 — the consumer takes the result.
- OUT output N+2 — signed result.
- ZF output 1 — the result is zero.
- NF output 1 — the result is negative (OUT[N+1]).
- VF output 1 — the result lies outside the N-bit signed range [-2^(N-1), 2^(N-1)-1].

## Operation
- Stage 1 (S1) is an input register holding X, Y, SEL and USE_ACC plus a valid bit.
- Stage 2 (S2) is a result register holding OUT, ZF, NF and VF plus a valid bit; out_valid is the S2 valid bit.
- Compute is combinational from S1 during the cycle in which S1 transfers into S2.
- Operand A = USE_ACC ? sat_N(ACC) : X.
  - sat_N clamps the (N+2)-bit ACC to [-2^(N-1), 2^(N-1)-1].
- Arithmetic is done in N+2-bit signed; "/2" is signed division truncating toward zero (-3/2 = -1, not -2).
  - 000: (A+Y)/2
  - 001: 2*(A+Y)
  - 010: A/2 + Y
  - 011: A - Y/2
- Logic is done on N bits, and the result is sign-extended to N+2.
  - 100: ~(A&Y)
  - 101: ~A
  - 110: ~(A|Y)
  - 111: A^Y
- No arithmetic result overflows N+2 bits; the extremes are 2*(-2^N) = -2^(N+1) and 2*(2^N-2).
- Flags are computed from the N+2-bit result and registered together with OUT.
- Accumulator ACC (N+2 bits) is loaded with each result in the same edge at which that result enters S2.
  - Because a USE_ACC operation is computed only when it moves S1→S2, it always sees the result of the immediately preceding operation. No interlock is needed.
- ACC_CLR=1 sets ACC to 0 at the next edge and takes priority over a simultaneous load from a result. That result is still delivered on OUT.

## Timing
- Reset (rst_n=0, asynchronous): S1/S2 valid = 0 and ACC = 0; OUT = 0, ZF = 0, NF = 0, VF = 0, out_valid = 0. in_ready = 1 while rst_n is low and after reset is released.
- Handshake control:
  - s2_adv = !out_valid || out_ready
  - s1_adv = S1valid && s2_adv
  - in_ready = !S1valid || s2_adv (combinational, no dependence on in_valid)
- Input transfer: in_valid && in_ready at an edge writes S1.
- S2 update at each edge:
  - s1_adv: S2 loads the new result.
  - otherwise, if out_ready: S2 valid clears.
  - otherwise: S2 holds.
- OUT and the flags are stable while out_valid=1 and out_ready=0. They keep the last value after drain.
- Latency: accepted at edge t, out_valid=1 after edge t+1.
- Sustained throughput is 1 op/cycle with out_ready tied to 1.
- Capacity is 2 entries. With out_ready=0, S2 fills first, then S1; in_ready then drops the cycle after S1 fills.
- Simultaneous accept and drain in the same cycle is allowed at both stages with no bubble.
- in_valid without in_ready: the inputs are ignored; the producer must hold them.
- Reset asserted mid-operation discards both stages immediately; no partial result is ever presented.

## Test plan
- N=4, stream (X=3,Y=4,SEL=000), (X=-3,Y=0,SEL=000), (X=7,Y=7,SEL=001) with out_ready=1 → back-to-back OUT = 3, -1, 28.
  - The 28 result has VF=1, NF=0.
  - The first result appears 2 cycles after its accept.
- Accumulate: (X=5,Y=0,SEL=001) → OUT=10, ACC=10.
  - Then (USE_ACC=1, Y=1, SEL=010) sees A=sat(10)=7 → OUT=4, issued on the very next cycle.
- Logic ops, N=4, X=0101, Y=0011:
  - SEL=100 → OUT=-2 (111110)
  - SEL=101 → -6
  - SEL=110 → -8
  - SEL=111 → 6
  - SEL=111 with X=Y → 0 and ZF=1.
- Backpressure: hold out_ready=0 and offer 3 ops.
  - Two are accepted and in_ready=0 on the third.
  - OUT stays constant.
  - Release out_ready: results emerge in order, none dropped or duplicated.
- ACC_CLR in the same cycle as a result load → that result is output, ACC=0.
  - A following USE_ACC op with SEL=000, Y=2 → OUT=1.
- Pull rst_n low with both stages full → out_valid, OUT, the flags and ACC go to 0 immediately (asynchronously) and in_ready=1.
  - After release, the first op behaves as in the first scenario.

Source files
------------

// File: rtl/alu_pipe_acc_if.sv
// Operand/result stream bundle for alu_pipe_acc: producer side (X, Y, SEL, USE_ACC)
// and consumer side (OUT and flags), each with its own valid/ready pair.
interface alu_pipe_acc_if #(parameter int N = 4);
  // Handshake: a beat transfers on a rising edge where valid && ready. A sender
  // holds its payload stable while valid is high and ready is low; ready never
  // depends on valid in the same cycle.
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic [2:0]   SEL;
  logic         USE_ACC;
  logic         ACC_CLR;
  logic         out_valid;
  logic         out_ready;
  logic [N+1:0] OUT;
  logic         ZF;
  logic         NF;
  logic         VF;

  modport master (
    output in_valid, X, Y, SEL, USE_ACC, ACC_CLR, out_ready,
    input  in_ready, out_valid, OUT, ZF, NF, VF
  );

  modport slave (
    input  in_valid, X, Y, SEL, USE_ACC, ACC_CLR, out_ready,
    output in_ready, out_valid, OUT, ZF, NF, VF
  );
endinterface

// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined signed ALU (input register S1, result register S2) with an
// accumulator that can stand in for operand A, plus zero/negative/overflow flags.
module alu_pipe_acc #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_pipe_acc_if.slave  bus,
  output logic [N+1:0]   dbg_acc
);
  localparam int W = N + 2;
  localparam logic signed [W-1:0] MAX_V = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {3'b111, {(N-1){1'b0}}};

  logic                s1_valid_q, s1_valid_d;
  logic [N-1:0]        x_q, x_d, y_q, y_d;
  logic [2:0]          sel_q, sel_d;
  logic                use_acc_q, use_acc_d;
  logic                s2_valid_q, s2_valid_d;
  logic signed [W-1:0] out_q, out_d;
  logic                zf_q, zf_d, nf_q, nf_d, vf_q, vf_d;
  logic signed [W-1:0] acc_q, acc_d;

  logic                s2_adv, s1_adv, in_ready;
  logic signed [W-1:0] sat_acc, a_w, y_w, sum_w, res;
  logic [N-1:0]        a_n, l_n;

  // Signed halving that truncates toward zero: bias negatives by +1 before the shift.
  function automatic logic signed [W-1:0] div2(input logic signed [W-1:0] v);
    logic signed [W-1:0] t;
    t = v + {{(W-1){1'b0}}, v[W-1]};
    return t >>> 1;
  endfunction

  always_comb begin
    sat_acc = acc_q;
    if (acc_q > MAX_V)      sat_acc = MAX_V;
    else if (acc_q < MIN_V) sat_acc = MIN_V;
    a_n   = use_acc_q ? sat_acc[N-1:0] : x_q;
    a_w   = {{2{a_n[N-1]}}, a_n};
    y_w   = {{2{y_q[N-1]}}, y_q};
    sum_w = a_w + y_w;
    l_n   = '0;
    res   = '0;
    case (sel_q)
      3'd0:    res = div2(sum_w);
      3'd1:    res = sum_w <<< 1;
      3'd2:    res = div2(a_w) + y_w;
      3'd3:    res = a_w - div2(y_w);
      3'd4:    l_n = ~(a_n & y_q);
      3'd5:    l_n = ~a_n;
      3'd6:    l_n = ~(a_n | y_q);
      default: l_n = a_n ^ y_q;
    endcase
    if (sel_q[2]) res = {{2{l_n[N-1]}}, l_n};
  end

  always_comb begin
    s2_adv   = !s2_valid_q || bus.out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    x_d        = x_q;
    y_d        = y_q;
    sel_d      = sel_q;
    use_acc_d  = use_acc_q;
    if (bus.in_valid && in_ready) begin
      s1_valid_d = 1'b1;
      x_d        = bus.X;
      y_d        = bus.Y;
      sel_d      = bus.SEL;
      use_acc_d  = bus.USE_ACC;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zf_d       = zf_q;
    nf_d       = nf_q;
    vf_d       = vf_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      out_d      = res;
      zf_d       = (res == '0);
      nf_d       = res[W-1];
      // Outside the N-bit signed range exactly when the top three bits disagree.
      vf_d       = !((&res[W-1:N-1]) || !(|res[W-1:N-1]));
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end

    acc_d = acc_q;
    if (bus.ACC_CLR)   acc_d = '0;
    else if (s1_adv)   acc_d = res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sel_q      <= '0;
      use_acc_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      zf_q       <= 1'b0;
      nf_q       <= 1'b0;
      vf_q       <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sel_q      <= sel_d;
      use_acc_q  <= use_acc_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      zf_q       <= zf_d;
      nf_q       <= nf_d;
      vf_q       <= vf_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.OUT       = out_q;
  assign bus.ZF        = zf_q;
  assign bus.NF        = nf_q;
  assign bus.VF        = vf_q;
  assign dbg_acc       = acc_q;
endmodule

// File: tb/tb_alu_pipe_acc.sv
// Directed bench for alu_pipe_acc (N=4): streaming, accumulate, logic ops,
// backpressure, accumulator clear and asynchronous reset, with an in-order scoreboard.
module tb_alu_pipe_acc;
  localparam int N = 4;
  localparam int SW = N + 5;

  logic         clk;
  logic         rst_n;
  logic [N+1:0] acc;
  int           checks;
  int           failures;
  logic [SW-1:0] exp_q[$];

  alu_pipe_acc_if #(.N(N)) bus ();

  alu_pipe_acc #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dbg_acc (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat: {VF, NF, ZF, OUT}; NF/ZF follow from the hand-computed value.
  function automatic logic [SW-1:0] pk(input int v, input logic vf);
    logic [N+1:0] o;
    o = (N+2)'(v);
    return {vf, o[N+1], (o == '0), o};
  endfunction

  task automatic step(output logic took);
    logic [SW-1:0] e;
    @(negedge clk);
    took = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=%0h expected=none",
               {bus.VF, bus.NF, bus.ZF, bus.OUT});
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_beat", 32'({bus.VF, bus.NF, bus.ZF, bus.OUT}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int sel, input logic ua);
    logic took;
    int   n;
    bus.X        = N'(x);
    bus.Y        = N'(y);
    bus.SEL      = 3'(sel);
    bus.USE_ACC  = ua;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      step(took);
      n++;
    end while (!took && n < 50);
    checks++;
    assert (took) else begin
      failures++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic drain();
    logic took;
    int   n;
    bus.in_valid = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step(took);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stream3();
    exp_q.push_back(pk(3, 1'b0));
    exp_q.push_back(pk(-1, 1'b0));
    exp_q.push_back(pk(28, 1'b1));
    send(3, 4, 0, 1'b0);
    chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
    send(-3, 0, 0, 1'b0);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_out", 32'($signed(bus.OUT)), 32'd3);
    send(7, 7, 1, 1'b0);
    drain();
  endtask

  initial begin
    logic took;
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.X        = '0;
    bus.Y        = '0;
    bus.SEL      = '0;
    bus.USE_ACC  = 1'b0;
    bus.ACC_CLR  = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'({bus.VF, bus.NF, bus.ZF, bus.OUT}), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back stream with latency checks.
    stream3();

    // Accumulate: second op uses saturated ACC (10 -> 7) on the very next cycle.
    exp_q.push_back(pk(10, 1'b1));
    exp_q.push_back(pk(4, 1'b0));
    send(5, 0, 1, 1'b0);
    send(0, 1, 2, 1'b1);
    chk("acc_after_load", 32'(acc), 32'd10);
    drain();
    chk("acc_after_use", 32'(acc), 32'd4);

    // Logic ops on X=0101, Y=0011.
    exp_q.push_back(pk(-2, 1'b0));
    exp_q.push_back(pk(-6, 1'b0));
    exp_q.push_back(pk(-8, 1'b0));
    exp_q.push_back(pk(6, 1'b0));
    exp_q.push_back(pk(0, 1'b0));
    send(5, 3, 4, 1'b0);
    send(5, 3, 5, 1'b0);
    send(5, 3, 6, 1'b0);
    send(5, 3, 7, 1'b0);
    send(5, 5, 7, 1'b0);
    drain();

    // Backpressure: two entries fill, third is refused, OUT holds.
    bus.out_ready = 1'b0;
    exp_q.push_back(pk(1, 1'b0));
    exp_q.push_back(pk(2, 1'b0));
    exp_q.push_back(pk(3, 1'b0));
    send(1, 1, 0, 1'b0);
    send(2, 2, 0, 1'b0);
    bus.X = 4'd3;
    bus.Y = 4'd3;
    bus.SEL = 3'd0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_hold", 32'($signed(bus.OUT)), 32'd1);
      step(took);
    end
    bus.out_ready = 1'b1;
    send(3, 3, 0, 1'b0);
    drain();

    // ACC_CLR in the same edge the result loads: result delivered, ACC cleared.
    exp_q.push_back(pk(10, 1'b1));
    exp_q.push_back(pk(1, 1'b0));
    send(5, 0, 1, 1'b0);
    bus.in_valid = 1'b0;
    bus.ACC_CLR  = 1'b1;
    step(took);
    bus.ACC_CLR  = 1'b0;
    chk("clr_acc", 32'(acc), 32'd0);
    chk("clr_out", 32'($signed(bus.OUT)), 32'd10);
    send(0, 2, 0, 1'b1);
    drain();

    // Asynchronous reset with both stages full; these results are discarded.
    bus.out_ready = 1'b0;
    send(1, 1, 1, 1'b0);
    send(2, 3, 1, 1'b0);
    bus.in_valid = 1'b0;
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    chk("full_out", 32'($signed(bus.OUT)), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_acc", 32'(acc), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out", 32'({bus.VF, bus.NF, bus.ZF, bus.OUT}), 32'd0);
    chk("arst_acc", 32'(acc), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    stream3();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
